// File: rtl/arduino_nibble_sender.sv
// Transmit controller for the 4-bit parallel Arduino link: fetches words from a
// synchronous memory and sends each one MSB nibble first, one strobe per nibble.
module arduino_nibble_sender #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DIV    = 25000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [3:0]        nib_out,
  output logic              strobe,
  output logic              busy,
  output logic              done
);

  localparam int NIB   = DATA_W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SETUP,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NIB_W-1:0]  nib_cnt_q, nib_cnt_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_next;

  logic [ADDR_W-1:0] addr_d;
  logic              rd_d;
  logic [3:0]        nib_d;
  logic              strobe_d;
  logic              busy_d;
  logic              done_d;

  assign shift_next = shift_q << 4;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      nib_cnt_q <= '0;
      words_q   <= '0;
      shift_q   <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      nib_out   <= 4'h0;
      strobe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nib_cnt_q <= nib_cnt_d;
      words_q   <= words_d;
      shift_q   <= shift_d;
      mem_addr  <= addr_d;
      mem_rd    <= rd_d;
      nib_out   <= nib_d;
      strobe    <= strobe_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Every output is computed here as the value it must hold in the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nib_cnt_d = nib_cnt_q;
    words_d   = words_q;
    shift_d   = shift_q;
    addr_d    = mem_addr;
    rd_d      = 1'b0;
    nib_d     = nib_out;
    strobe_d  = strobe;
    busy_d    = busy;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          words_d = num_words;
          busy_d  = 1'b1;
          if (num_words == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH;
            rd_d    = 1'b1;
          end
        end
      end

      ST_FETCH: state_d = ST_WAIT;

      // Read data becomes valid here; load it and present the top nibble.
      ST_WAIT: begin
        state_d   = ST_SETUP;
        shift_d   = mem_data;
        nib_d     = mem_data[DATA_W-1 -: 4];
        nib_cnt_d = '0;
        cnt_d     = '0;
        strobe_d  = 1'b0;
      end

      ST_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d  = ST_HOLD;
          strobe_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d    = '0;
          strobe_d = 1'b0;
          if (nib_cnt_q < NIB_LAST) begin
            state_d   = ST_SETUP;
            shift_d   = shift_next;
            nib_d     = shift_next[DATA_W-1 -: 4];
            nib_cnt_d = nib_cnt_q + NIB_W'(1);
          end else if (words_q > ADDR_W'(1)) begin
            state_d = ST_FETCH;
            rd_d    = 1'b1;
            addr_d  = mem_addr + ADDR_W'(1);
            words_d = words_q - ADDR_W'(1);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        strobe_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state logic chose above.
    if (state_q != ST_IDLE && abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      rd_d     = 1'b0;
      nib_d    = 4'h0;
      strobe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_arduino_nibble_sender.sv
// Self-checking bench for arduino_nibble_sender (DIV=2): vector table of whole
// transfers plus hand sequences for start-while-busy, abort and mid-transfer reset.
module tb_arduino_nibble_sender;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DIV    = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [3:0]        nib_out;
  logic              strobe;
  logic              busy;
  logic              done;

  arduino_nibble_sender #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .nib_out(nib_out), .strobe(strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data for a read appears after the edge that sees mem_rd.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] mem_q = '0;
  always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];
  assign mem_data = mem_q;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic [ADDR_W-1:0] addr_q[$];
  logic [3:0]        nib_q[$];
  int                done_cnt, busy_cnt, done_edge, first_rise_edge, start_k;
  logic              strobe_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_rd) addr_q.push_back(mem_addr);
    if (strobe && !strobe_prev) begin
      nib_q.push_back(nib_out);
      if (nib_q.size() == 1) first_rise_edge = edge_cnt;
    end
    strobe_prev = strobe;
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
    end
    if (busy) busy_cnt++;
  end

  int total = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic clearMon();
    addr_q.delete();
    nib_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
    done_edge = 0;
    first_rise_edge = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] n);
    @(negedge clk);
    clearMon();
    base_addr = b;
    num_words = n;
    start = 1'b1;
    start_k = edge_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_timeout"}, 64'(k >= 400), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitNibs(input int n, input string name);
    int k;
    k = 0;
    while (nib_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_timeout"}, 64'(k >= 200), 64'd0);
  endtask

  function automatic logic [47:0] packNibs();
    logic [47:0] v;
    v = '0;
    foreach (nib_q[i]) v = {v[43:0], nib_q[i]};
    return v;
  endfunction

  function automatic logic [23:0] packAddrs();
    logic [23:0] v;
    v = '0;
    foreach (addr_q[i]) v = {v[15:0], addr_q[i]};
    return v;
  endfunction

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  num;
    logic [15:0] w0, w1, w2;
    int          exp_rd;
    logic [23:0] exp_addrs;
    int          exp_rises;
    logic [47:0] exp_nibs;
    int          exp_busy;
  } vec_t;

  vec_t vecs[4];

  task automatic loadMem(input int i);
    logic [7:0] a;
    a = vecs[i].base;
    mem[a] = vecs[i].w0;
    a = a + 8'd1;
    mem[a] = vecs[i].w1;
    a = a + 8'd1;
    mem[a] = vecs[i].w2;
  endtask

  task automatic runVector(input int i);
    string tag;
    tag = $sformatf("v%0d", i);
    loadMem(i);
    applyStimulus(vecs[i].base, vecs[i].num);
    waitDone(tag);
    checkOutput({tag, "_rd_count"}, 64'(addr_q.size()), 64'(vecs[i].exp_rd));
    checkOutput({tag, "_rd_addrs"}, 64'(packAddrs()), 64'(vecs[i].exp_addrs));
    checkOutput({tag, "_rises"}, 64'(nib_q.size()), 64'(vecs[i].exp_rises));
    checkOutput({tag, "_nibbles"}, 64'(packNibs()), 64'(vecs[i].exp_nibs));
    checkOutput({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(vecs[i].exp_busy));
    checkOutput({tag, "_done_latency"}, 64'(done_edge - start_k), 64'(vecs[i].exp_busy));
    if (vecs[i].exp_rises > 0)
      checkOutput({tag, "_first_rise_latency"}, 64'(first_rise_edge - start_k), 64'(3 + DIV));
  endtask

  initial begin
    // Per word: FETCH + WAIT + 4 nibbles * 2*DIV = 18 cycles, plus one DONE cycle.
    vecs[0] = '{8'h10, 8'd1, 16'hA5C3, 16'h0000, 16'h0000, 1, 24'h000010, 4, 48'hA5C3, 19};
    vecs[1] = '{8'h00, 8'd0, 16'h0000, 16'h0000, 16'h0000, 0, 24'h000000, 0, 48'h0, 1};
    vecs[2] = '{8'hFE, 8'd3, 16'h1234, 16'h5678, 16'h9ABC, 3, 24'hFEFF00, 12, 48'h123456789ABC, 55};
    vecs[3] = '{8'h20, 8'd2, 16'h0F0F, 16'hFFFF, 16'h0000, 2, 24'h002021, 8, 48'h0F0FFFFF, 37};

    for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;

    reset = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    base_addr = 8'h33;
    num_words = 8'd2;
    clearMon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", 64'({mem_addr, mem_rd, nib_out, strobe, busy, done}), 64'd0);
    checkOutput("reset_no_rd", 64'(addr_q.size()), 64'd0);
    reset = 1'b1;
    start = 1'b0;

    for (int i = 0; i < 4; i++) runVector(i);

    // start pulsed while in HOLD must not disturb the running transfer.
    loadMem(0);
    applyStimulus(8'h10, 8'd1);
    waitNibs(1, "busy_start_wait");
    base_addr = 8'h55;
    num_words = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("busy_start");
    checkOutput("busy_start_nibbles", 64'(packNibs()), 64'hA5C3);
    checkOutput("busy_start_rd_addrs", 64'(packAddrs()), 64'h10);
    checkOutput("busy_start_done_count", 64'(done_cnt), 64'd1);
    checkOutput("busy_start_busy_cycles", 64'(busy_cnt), 64'd19);

    // Abort while the second nibble is strobed high.
    applyStimulus(8'h10, 8'd1);
    waitNibs(2, "abort_wait");
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_outputs", 64'({mem_rd, nib_out, strobe, busy, done}), 64'd0);
    abort = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
    checkOutput("abort_nibbles", 64'(packNibs()), 64'hA5);
    checkOutput("abort_still_idle", 64'({strobe, busy}), 64'd0);

    // Reset during the third nibble of the wrapping transfer, then rerun it.
    loadMem(2);
    applyStimulus(8'hFE, 8'd3);
    waitNibs(3, "midreset_wait");
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_outputs", 64'({mem_addr, mem_rd, nib_out, strobe, busy, done}), 64'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("midreset_no_done", 64'(done_cnt), 64'd0);
    checkOutput("midreset_rises", 64'(nib_q.size()), 64'd3);
    runVector(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
